// File: rtl/core_pkg.sv
// Shared constants and types for the writeback/commit slice of the core.
package core_pkg;

  localparam int unsigned CORE_ADDR_W = 5;
  localparam int unsigned CORE_DATA_W = 32;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [CORE_ADDR_W-1:0] rd;
    logic [CORE_DATA_W-1:0] data;
  } wb_req_t;

endpackage : core_pkg

// File: rtl/core_wb_fifo.sv
// Small synchronous FIFO of pending load writebacks. Exposes every entry and
// its valid bit so the parent can build the busy scoreboard.
module core_wb_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       push_i,
  input  wb_req_t                    push_data_i,
  input  logic                       pop_i,
  output wb_req_t                    head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           valid_o,
  output wb_req_t                    entries_o [DEPTH]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [DEPTH-1:0] valid_q,  valid_d;
  wb_req_t          mem_q [DEPTH];

  // Next-state for pointers, occupancy and per-entry valid bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;  // DEPTH is a power of 2: wraps naturally
    end
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry storage.
  // NOTE: storage has no reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign valid_o   = valid_q;
  assign entries_o = mem_q;

endmodule : core_wb_fifo

// File: rtl/core_wb_commit.sv
// Writeback commit: arbitrates ALU vs queued load results onto the regfile
// write port, forwards last cycle's write over the registered regfile read,
// and publishes busy bits for registers targeted by queued loads.
module core_wb_commit
  import core_pkg::*;
#(
  parameter int unsigned LSU_FIFO_DEPTH = 2,
  parameter int unsigned ADDR_W         = CORE_ADDR_W,
  parameter int unsigned DATA_W         = CORE_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  alu_valid_i,
  input  logic [ADDR_W-1:0]     alu_rd_i,
  input  logic [DATA_W-1:0]     alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_W-1:0]     lsu_rd_i,
  input  logic [DATA_W-1:0]     lsu_data_i,
  output logic                  rd_we_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  output logic [DATA_W-1:0]     rd_data_o,
  input  logic [ADDR_W-1:0]     rs0_addr_i,
  input  logic [ADDR_W-1:0]     rs1_addr_i,
  input  logic [DATA_W-1:0]     rs0_rf_data_i,
  input  logic [DATA_W-1:0]     rs1_rf_data_i,
  output logic [DATA_W-1:0]     rs0_data_o,
  output logic [DATA_W-1:0]     rs1_data_o,
  output logic [2**ADDR_W-1:0]  busy_o
);

  logic                           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(LSU_FIFO_DEPTH):0] fifo_count;
  logic [LSU_FIFO_DEPTH-1:0]      fifo_valid;
  wb_req_t                        fifo_head;
  wb_req_t                        fifo_entries [LSU_FIFO_DEPTH];
  wb_req_t                        lsu_req;

  logic                           fwd_vld_q,  fwd_vld_d;
  logic [ADDR_W-1:0]              fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0]              fwd_data_q, fwd_data_d;
  logic [ADDR_W-1:0]              rs0_q, rs0_d, rs1_q, rs1_d;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign lsu_ready_o  = !fifo_full;
  assign fifo_push    = lsu_valid_i && lsu_ready_o;
  assign fifo_pop     = !alu_valid_i && !fifo_empty;
  assign lsu_req.rd   = lsu_rd_i;
  assign lsu_req.data = lsu_data_i;

  core_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .push_i      (fifo_push),
    .push_data_i (lsu_req),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .entries_o   (fifo_entries)
  );

  // Commit arbitration: ALU has priority, otherwise drain the load FIFO head.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    rd_we_o   = 1'b0;
    rd_addr_o = '0;
    rd_data_o = '0;
    if (alu_valid_i) begin
      rd_addr_o = alu_rd_i;
      rd_data_o = alu_data_i;
      rd_we_o   = (alu_rd_i != '0);
    end else if (!fifo_empty) begin
      rd_addr_o = fifo_head.rd;
      rd_data_o = fifo_head.data;
      rd_we_o   = (fifo_head.rd != '0);
    end
  end

  // Next-state for the one-entry write-forward and the delayed read addresses.
  always_comb begin
    fwd_vld_d  = rd_we_o;
    fwd_addr_d = rd_addr_o;
    fwd_data_d = rd_data_o;
    rs0_d      = rs0_addr_i;
    rs1_d      = rs1_addr_i;
  end

  // Forwarding state register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
      rs0_q      <= '0;
      rs1_q      <= '0;
    end else begin
      fwd_vld_q  <= fwd_vld_d;
      fwd_addr_q <= fwd_addr_d;
      fwd_data_q <= fwd_data_d;
      rs0_q      <= rs0_d;
      rs1_q      <= rs1_d;
    end
  end

  // Operand correction: override the stale regfile read with last cycle's write.
  always_comb begin
    rs0_data_o = rs0_rf_data_i;
    rs1_data_o = rs1_rf_data_i;
    if (fwd_vld_q && (fwd_addr_q == rs0_q) && (rs0_q != '0)) rs0_data_o = fwd_data_q;
    if (fwd_vld_q && (fwd_addr_q == rs1_q) && (rs1_q != '0)) rs1_data_o = fwd_data_q;
  end

  // Busy scoreboard: one bit per register targeted by a valid queued load; x0 never busy.
  always_comb begin
    busy_o = '0;
    for (int i = 0; i < int'(LSU_FIFO_DEPTH); i++) begin
      if (fifo_valid[i]) busy_o[fifo_entries[i].rd] = 1'b1;
    end
    busy_o[0] = 1'b0;
  end

endmodule : core_wb_commit
